uart_tx_rx: RTL and testbench
=============================

UART_TX_RX -- requirements
Module: uart_tx_rx

Interface
REQ-001 SHALL have parameter c_CYCLES_PER_BIT, default 434, giving clock cycles per UART bit (50 MHz / 115200 baud); legal range >= 4.
REQ-002 SHALL have port i_CLK  input  1  single system clock; all logic on the rising edge.
REQ-003 SHALL have port i_RESET  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_TX_DV  input  1  transmit request strobe.
REQ-005 SHALL have port i_PARALLEL_DATA  input  8  byte to transmit.
REQ-006 SHALL have port o_SERIAL_DATA  output  1  TX serial line.
REQ-007 SHALL have port o_TX_ACTIVE  output  1  high while a TX frame is in progress.
REQ-008 SHALL have port o_TX_DONE  output  1  one-cycle pulse at TX frame end.
REQ-009 SHALL have port i_SERIAL_DATA  input  1  RX serial line; idle high.
REQ-010 SHALL have port o_DATA_RX  output  8  last received byte.
REQ-011 SHALL have port o_RX_DATA_VALID  output  1  one-cycle pulse when o_DATA_RX is updated.

Function
REQ-012 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each bit exactly c_CYCLES_PER_BIT cycles.
REQ-013 TX FSM SHALL have states IDLE, START, DATA, STOP; IDLE drives o_SERIAL_DATA=1.
REQ-014 In IDLE, i_TX_DV=1 SHALL latch i_PARALLEL_DATA and enter START; o_TX_ACTIVE rises and o_SERIAL_DATA falls on the next cycle.
REQ-015 i_TX_DV SHALL be ignored while o_TX_ACTIVE=1.
REQ-016 After the stop bit's last cycle, o_TX_DONE SHALL pulse high for 1 cycle; o_TX_ACTIVE falls on the same cycle. A new frame may start on the following cycle.
REQ-017 RX FSM SHALL have states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-018 RX IDLE SHALL enter START when the sampled line is 0.
REQ-019 START SHALL recheck the line after (c_CYCLES_PER_BIT-1)/2 cycles: 0 enters DATA; 1 returns to IDLE (glitch rejected, no output).
REQ-020 DATA SHALL sample each bit every c_CYCLES_PER_BIT cycles from the mid-start point, shifting the bit in LSB first.
REQ-021 STOP SHALL sample mid-stop-bit. If the sample is 1, o_DATA_RX SHALL update and o_RX_DATA_VALID SHALL pulse for 1 cycle, then the FSM returns to IDLE. If the sample is 0 (framing error), output SHALL be suppressed and the FSM enters WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL return to IDLE only when the line is 1.
REQ-023 o_DATA_RX SHALL hold its value between valid pulses.
REQ-024 Bit counters SHALL be $clog2(c_CYCLES_PER_BIT) wide; bit index 3 bits, wrapping 7->0 only on the DATA exit.
REQ-025 TX and RX SHALL be fully independent; simultaneous operation is legal.

Reset
REQ-026 Asserting i_RESET low SHALL immediately force both FSMs to IDLE and all counters to 0, with outputs o_SERIAL_DATA=1, o_TX_ACTIVE=0, o_TX_DONE=0, o_DATA_RX=0x00, o_RX_DATA_VALID=0.
REQ-027 Reset mid-frame SHALL abort the frame with no done or valid pulse.

Configuration
REQ-028 With macro UART_RX_SYNC_EN defined, i_SERIAL_DATA SHALL pass through a 2-flop synchronizer (reset value 1) before the RX FSM, adding 2 cycles of latency.
REQ-029 Without UART_RX_SYNC_EN, the RX FSM SHALL sample i_SERIAL_DATA through a single register (reset value 1).

Structure
REQ-030 A shared package uart_pkg SHALL hold the TX and RX state encodings, the data width constant (8), and the idle/start/stop level constants.
REQ-031 The bit timer (cycle counter with half-bit and full-bit terminal flags) SHALL be a sub-module uart_bit_timer, instantiated once by TX and once by RX.

Verification
REQ-032 Loopback at c_CYCLES_PER_BIT=8 (o_SERIAL_DATA -> i_SERIAL_DATA), send 0xCB -> o_RX_DATA_VALID pulses once with o_DATA_RX=0xCB; o_TX_DONE pulses 80 cycles after TX start.
REQ-033 Back-to-back sends 0x00 then 0xFF, with i_TX_DV reasserted on the o_TX_DONE cycle -> both bytes received in order, no dropped frame.
REQ-034 A 2-cycle low glitch on an idle RX line -> no o_RX_DATA_VALID, and the RX FSM is back in IDLE.
REQ-035 An RX frame 0x55 with stop bit forced 0 -> no valid pulse, o_DATA_RX unchanged, and a following good frame 0xA5 is received correctly.
REQ-036 i_RESET low during TX data bit 3 -> o_SERIAL_DATA=1 and o_TX_ACTIVE=0 immediately, with no o_TX_DONE.
REQ-037 i_TX_DV pulsed mid-frame with 0x12 -> ignored; only the original byte is transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame data width, line levels and TX/RX state encodings.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic LVL_IDLE  = 1'b1;
  localparam logic LVL_START = 1'b0;
  localparam logic LVL_STOP  = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period cycle counter with half-bit and full-bit terminal flags.
// Counter holds at zero while disabled or cleared and wraps after the full-bit cycle.
module uart_bit_timer #(
  parameter int unsigned c_CYCLES_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic half_o,
  output logic full_o
);

  localparam int unsigned   CW   = $clog2(c_CYCLES_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((c_CYCLES_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL = CW'(c_CYCLES_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == FULL) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_o = en_i && (cnt_q == HALF);
  assign full_o = en_i && (cnt_q == FULL);

endmodule

// File: rtl/uart_tx_rx.sv
// Independent 8N1 UART transmitter and receiver sharing one clock.
// Define UART_RX_SYNC_EN to add a 2-flop synchronizer ahead of the RX sample register.
module uart_tx_rx
  import uart_pkg::*;
#(
  parameter int unsigned c_CYCLES_PER_BIT = 434
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic              i_TX_DV,
  input  logic [DATA_W-1:0] i_PARALLEL_DATA,
  output logic              o_SERIAL_DATA,
  output logic              o_TX_ACTIVE,
  output logic              o_TX_DONE,
  input  logic              i_SERIAL_DATA,
  output logic [DATA_W-1:0] o_DATA_RX,
  output logic              o_RX_DATA_VALID
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_W - 1);

  tx_state_e         tx_state_q, tx_state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [2:0]        tx_idx_q, tx_idx_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_full, tx_half_unused;

  uart_bit_timer #(.c_CYCLES_PER_BIT(c_CYCLES_PER_BIT)) u_tx_timer (
    .clk_i  (i_CLK),
    .rst_ni (i_RESET),
    .en_i   (tx_state_q != TX_IDLE),
    .clr_i  (1'b0),
    .half_o (tx_half_unused),
    .full_o (tx_full)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_idx_d   = tx_idx_q;
    tx_done_d  = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: if (i_TX_DV) begin
        tx_data_d  = i_PARALLEL_DATA;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_full) begin
        tx_idx_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_full) begin
        tx_idx_d = tx_idx_q + 3'd1;
        if (tx_idx_q == LAST_IDX) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_full) begin
        tx_done_d  = 1'b1;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    o_SERIAL_DATA = LVL_IDLE;
    unique case (tx_state_q)
      TX_START: o_SERIAL_DATA = LVL_START;
      TX_DATA:  o_SERIAL_DATA = tx_data_q[tx_idx_q];
      TX_STOP:  o_SERIAL_DATA = LVL_STOP;
      default:  o_SERIAL_DATA = LVL_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      tx_state_q <= TX_IDLE;
      tx_data_q  <= '0;
      tx_idx_q   <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      tx_idx_q   <= tx_idx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign o_TX_ACTIVE = (tx_state_q != TX_IDLE);
  assign o_TX_DONE   = tx_done_q;

  logic rx_s_q;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync_q;
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      rx_sync_q <= '1;
      rx_s_q    <= LVL_IDLE;
    end else begin
      rx_sync_q <= {rx_sync_q[0], i_SERIAL_DATA};
      rx_s_q    <= rx_sync_q[1];
    end
  end
`else
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      rx_s_q <= LVL_IDLE;
    end else begin
      rx_s_q <= i_SERIAL_DATA;
    end
  end
`endif

  rx_state_e         rx_state_q, rx_state_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [2:0]        rx_idx_q, rx_idx_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_half, rx_full;

  // Restarting the timer at the confirmed mid-start point makes every later
  // full-bit tick land in the middle of a data or stop bit.
  uart_bit_timer #(.c_CYCLES_PER_BIT(c_CYCLES_PER_BIT)) u_rx_timer (
    .clk_i  (i_CLK),
    .rst_ni (i_RESET),
    .en_i   ((rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_IDLE)),
    .clr_i  ((rx_state_q == RX_START) && rx_half),
    .half_o (rx_half),
    .full_o (rx_full)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_idx_d   = rx_idx_q;
    rx_valid_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: if (rx_s_q == LVL_START) rx_state_d = RX_START;
      RX_START: if (rx_half) begin
        rx_idx_d   = '0;
        rx_state_d = (rx_s_q == LVL_START) ? RX_DATA : RX_IDLE;
      end
      RX_DATA: if (rx_full) begin
        rx_shift_d = {rx_s_q, rx_shift_q[DATA_W-1:1]};
        rx_idx_d   = rx_idx_q + 3'd1;
        if (rx_idx_q == LAST_IDX) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_full) begin
        if (rx_s_q == LVL_STOP) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_WAIT_IDLE;
        end
      end
      RX_WAIT_IDLE: if (rx_s_q == LVL_IDLE) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_idx_q   <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_idx_q   <= rx_idx_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign o_DATA_RX       = rx_data_q;
  assign o_RX_DATA_VALID = rx_valid_q;

endmodule

// File: tb/tb_uart_tx_rx.sv
// Randomized bench for uart_tx_rx: frame-level TX waveform model plus an RX byte scoreboard.
module tb_uart_tx_rx;

  localparam int unsigned C     = 8;
  localparam int          FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_data = '0;
  logic       serial_o, tx_active, tx_done;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;

  assign rx_line = loop_en ? serial_o : rx_drv;

  always #5 clk = ~clk;

  uart_tx_rx #(.c_CYCLES_PER_BIT(C)) dut (
    .i_CLK           (clk),
    .i_RESET         (rst_n),
    .i_TX_DV         (tx_dv),
    .i_PARALLEL_DATA (tx_data),
    .o_SERIAL_DATA   (serial_o),
    .o_TX_ACTIVE     (tx_active),
    .o_TX_DONE       (tx_done),
    .i_SERIAL_DATA   (rx_line),
    .o_DATA_RX       (rx_data),
    .o_RX_DATA_VALID (rx_valid)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [7:0]  b;
    int unsigned deadline;
  } exp_t;
  exp_t rxq[$];

  // TX model: a frame is 10 bit slots of C cycles counted from the accepting edge.
  bit         m_busy = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = '0;
  bit         m_done = 1'b0;
  logic [7:0] m_rxdata = '0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_serial();
    int p;
    if (!m_busy) return 1'b1;
    p = m_t / C;
    if (p == 0) return 1'b0;
    if (p <= 8) return m_byte[p-1];
    return 1'b1;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 1'b0; m_t = 0; m_done = 1'b0; m_rxdata = '0;
        rxq.delete();
      end
      chk("tx_serial", serial_o, exp_serial());
      chk("tx_active", tx_active, m_busy);
      chk("tx_done", tx_done, m_done);
      if (rx_valid) begin
        if (rxq.size() == 0) chk("rx_unexpected_valid", 1, 0);
        else begin
          e = rxq.pop_front();
          m_rxdata = e.b;
        end
      end else if (rxq.size() > 0 && cyc > rxq[0].deadline) begin
        chk("rx_missing_valid", 0, 1);
        e = rxq.pop_front();
      end
      chk("rx_data", rx_data, m_rxdata);
      m_done = 1'b0;
      if (rst_n) begin
        if (m_busy) begin
          m_t++;
          if (m_t == FRAME) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end else if (tx_dv) begin
          m_busy = 1'b1;
          m_t = 0;
          m_byte = tx_data;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rxq.push_back('{b, cyc + FRAME + 3 * C});
  endtask

  task automatic send_tx(input logic [7:0] b, input bit expect_rx);
    tx_dv = 1'b1;
    tx_data = b;
    if (expect_rx) push_rx(b);
    tick(1);
    tx_dv = 1'b0;
  endtask

  task automatic wait_tx_done(output int n);
    bit got;
    n = 0;
    got = 1'b0;
    while (n < 400 && !got) begin
      tick(1);
      n++;
      got = tx_done;
    end
    chk("tx_done_seen", got, 1);
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (tx_active && n < 300) begin
      tick(1);
      n++;
    end
    chk("tx_idle_wait", tx_active, 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input bit with_tx);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (stop) push_rx(b);
    for (int k = 0; k < 10; k++) begin
      rx_drv = fr[k];
      if (k == 0 && with_tx) begin
        tx_dv = 1'b1;
        tx_data = 8'($urandom);
      end
      tick(1);
      tx_dv = 1'b0;
      tick(C - 1);
    end
    rx_drv = 1'b1;
    tick(2 * C);
  endtask

  initial begin
    int n;
    logic [7:0] b;
    rst_n = 1'b0;
    tick(3);
    chk("rst_serial", serial_o, 1);
    chk("rst_active", tx_active, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    rst_n = 1'b1;
    tick(2);

    loop_en = 1'b1;
    send_tx(8'hCB, 1'b1);
    wait_tx_done(n);
    chk("cb_done_latency", n, 80);
    tick(C);
    chk("cb_rx_data", rx_data, 8'hCB);

    send_tx(8'h00, 1'b1);
    wait_tx_done(n);
    send_tx(8'hFF, 1'b1);
    wait_tx_done(n);
    chk("b2b_done_latency", n, 80);
    tick(C);
    chk("b2b_rx_data", rx_data, 8'hFF);
    chk("b2b_all_received", rxq.size(), 0);

    send_tx(8'h3C, 1'b1);
    tick(20);
    tx_dv = 1'b1;
    tx_data = 8'h12;
    tick(1);
    tx_dv = 1'b0;
    wait_tx_done(n);
    chk("ignore_done_latency", n, 80 - 21);
    tick(C);
    chk("ignore_rx_data", rx_data, 8'h3C);

    loop_en = 1'b0;
    rx_drv = 1'b0;
    tick(2);
    rx_drv = 1'b1;
    tick(3 * C);
    chk("glitch_rx_data", rx_data, 8'h3C);
    send_rx(8'h3A, 1'b1, 1'b0);
    chk("after_glitch_rx_data", rx_data, 8'h3A);

    send_rx(8'h55, 1'b0, 1'b0);
    chk("ferr_hold", rx_data, 8'h3A);
    send_rx(8'hA5, 1'b1, 1'b0);
    chk("after_ferr_rx_data", rx_data, 8'hA5);

    for (int i = 0; i < 16; i++) begin
      wait_tx_idle();
      b = 8'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        loop_en = 1'b1;
        send_tx(b, 1'b1);
        if ($urandom_range(1, 0) == 1) begin
          tick($urandom_range(70, 1));
          tx_dv = 1'b1;
          tx_data = 8'($urandom);
          tick(1);
          tx_dv = 1'b0;
        end
        wait_tx_done(n);
        tick($urandom_range(3, 0));
      end else begin
        loop_en = 1'b0;
        send_rx(b, ($urandom_range(3, 0) != 0), ($urandom_range(1, 0) == 1));
      end
    end

    wait_tx_idle();
    tick(2 * C);
    loop_en = 1'b0;
    send_tx(8'hB7, 1'b0);
    tick(33);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_serial", serial_o, 1);
    chk("midrst_active", tx_active, 0);
    chk("midrst_done", tx_done, 0);
    chk("midrst_rx_data", rx_data, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(FRAME + 2 * C);
    chk("postrst_active", tx_active, 0);

    n = 0;
    while (rxq.size() > 0 && n < 400) begin
      tick(1);
      n++;
    end
    chk("rx_queue_drained", rxq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
